// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin front end that time-shares one 8-entry, 4-bit sorter
// between two frame requesters and returns each sorted frame tagged with its owner.
module sort_arbiter #(
    parameter int FRAME   = 8,
    parameter int W       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         dout_id,
    output logic         done,
    output logic         err,
    output logic         s_load,
    output logic         s_sort,
    output logic         s_send,
    output logic [W-1:0] s_data_in,
    input  logic         s_ready,
    input  logic         s_busy,
    input  logic         s_waiting,
    input  logic [W-1:0] s_data_out
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] COLLECT = 3'd4;
    localparam logic [2:0] FIN     = 3'd5;
    localparam logic [3:0] LAST_IDX = 4'(FRAME - 1);
    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

    logic [2:0]   r_state;
    logic         r_cur;
    logic         r_last;
    logic [3:0]   r_cnt;
    logic [7:0]   r_wait;
    logic [W-1:0] r_dout;
    logic         r_dout_valid;
    logic         r_done;
    logic         w_pick;
    logic         w_start;
    logic         w_load;
    logic         w_timeout;
    logic         w_unused;

    // s_busy carries no information the FSM needs beyond s_ready/s_waiting
    assign w_unused  = s_busy;
    assign w_pick    = (req0 && req1) ? ~r_last : req1;
    assign w_start   = (r_state == IDLE) && s_ready && (req0 || req1);
    assign w_load    = (r_state == LOAD);
    assign w_timeout = (r_wait == WAIT_MAX) &&
                       (((r_state == SETTLE) && !s_ready) || ((r_state == RUN) && !s_waiting));

    assign gnt0       = w_load && !r_cur;
    assign gnt1       = w_load && r_cur;
    assign s_data_in  = w_load ? (r_cur ? din1 : din0) : '0;
    assign s_load     = w_load && (r_cnt == 4'd0);
    assign s_sort     = (r_state == SETTLE) && s_ready;
    assign s_send     = (r_state == RUN) && s_waiting;
    assign err        = w_timeout;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_id    = r_cur;
    assign done       = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur        <= 1'b0;
            r_last       <= 1'b1;
            r_cnt        <= 4'd0;
            r_wait       <= 8'd0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done       <= (r_state == FIN);
            r_dout_valid <= (r_state == COLLECT);
            r_cnt        <= (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
            r_wait       <= (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cur   <= w_pick;
                        r_cnt   <= 4'd0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_cnt == LAST_IDX) begin
                        r_wait  <= 8'd0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (s_sort) begin
                        r_wait  <= 8'd0;
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (s_send) begin
                        r_cnt   <= 4'd0;
                        r_state <= COLLECT;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                COLLECT: begin
                    r_dout <= s_data_out;
                    if (r_cnt == LAST_IDX) r_state <= FIN;
                end
                FIN: begin
                    r_last  <= r_cur;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: directed bench with a behavioural sorter stub and a frame-level
// scoreboard predicting arbitration order, sorted results and protocol timing.
module tb_sort_arbiter;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [3:0]  din0, din1, dout, s_data_in;
    logic [3:0]  s_data_out;
    logic        gnt0, gnt1, dout_valid, dout_id, done, err, s_load, s_sort, s_send;
    logic        s_ready, s_busy, s_waiting;
    logic [31:0] f0 = 32'h0;
    logic [31:0] f1 = 32'h0;
    logic [2:0]  gi;
    logic        hang = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sort_arbiter #(.FRAME(8), .W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id),
        .done(done), .err(err), .s_load(s_load), .s_sort(s_sort), .s_send(s_send),
        .s_data_in(s_data_in), .s_ready(s_ready), .s_busy(s_busy), .s_waiting(s_waiting),
        .s_data_out(s_data_out)
    );

    function automatic logic [31:0] sort_desc(input logic [31:0] f);
        int v[8];
        logic [31:0] r;
        for (int i = 0; i < 8; i++) v[i] = int'(f[4*i +: 4]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (v[j] < v[j+1]) begin
                    int t = v[j];
                    v[j] = v[j+1];
                    v[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(v[i]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame sources: element k presented in the k-th grant cycle
    always @(posedge clk or posedge rst)
        if (rst) gi <= 3'd0;
        else gi <= (gnt0 | gnt1) ? gi + 3'd1 : 3'd0;
    assign din0 = f0[4*gi +: 4];
    assign din1 = f1[4*gi +: 4];

    always @(posedge clk) cyc <= cyc + 1;

    // Sorter stub: idle(0) load(1) init(2) sort(3) waiting(4) send(5)
    int          st, sc;
    logic [31:0] sbuf;
    assign s_ready   = (st == 0);
    assign s_waiting = (st == 4);
    assign s_busy    = st inside {1, 2, 3, 5};
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= 0; sc <= 0; sbuf <= 32'h0; s_data_out <= 4'h0;
        end else begin
            case (st)
                0: if (s_load) begin sbuf[3:0] <= s_data_in; sc <= 1; st <= 1; end
                   else if (s_sort) begin sbuf <= sort_desc(sbuf); sc <= 0; st <= 3; end
                1: begin
                    sbuf[4*sc +: 4] <= s_data_in;
                    if (sc == 7) begin sc <= 0; st <= 2; end else sc <= sc + 1;
                end
                2: if (!hang) begin
                    if (sc == 2) begin sc <= 0; st <= 0; end else sc <= sc + 1;
                end
                3: if (sc == 4) begin sc <= 0; st <= 4; end else sc <= sc + 1;
                4: if (s_send) begin s_data_out <= sbuf[3:0]; sc <= 1; st <= 5; end
                5: begin
                    s_data_out <= sbuf[4*sc +: 4];
                    if (sc == 7) begin sc <= 0; st <= 0; end else sc <= sc + 1;
                end
                default: st <= 0;
            endcase
        end
    end

    // Scoreboard: frame-level model of the arbiter's contract
    exp_t        exp_q[$];
    exp_t        e;
    logic        served[$];
    logic [3:0]  got[$];
    logic        m_last = 1'b1;
    logic        cur_id = 1'b0;
    logic        pr0 = 1'b0, pr1 = 1'b0, prdy = 1'b0;
    logic [31:0] frame = 32'h0;
    int gcnt = 0, vcnt = 0, n_sort = 0, n_send = 0, send_cyc = 0;
    int last_gnt_cyc = 0, n_done = 0, n_err = 0, n_loads = 0, err_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_last = 1'b1; gcnt = 0; vcnt = 0; n_sort = 0; n_send = 0;
        end else begin
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            chk("ctl_exclusive", $countones({s_load, s_sort, s_send}) <= 1, 1);
            chk("done_timing", done, !dout_valid && vcnt != 0);
            if (s_load) begin
                n_loads++;
                chk("load_ready", s_ready, 1);
                chk("load_first_gnt", (gnt0 | gnt1) && gcnt == 0, 1);
            end
            if (s_sort) n_sort++;
            if (s_send) begin n_send++; send_cyc = cyc; end
            if (gnt0 | gnt1) begin
                if (gcnt == 0) begin
                    cur_id = gnt1;
                    served.push_back(gnt1);
                    frame = 32'h0;
                    chk("winner", gnt1, (pr0 && pr1) ? !m_last : pr1);
                    chk("arb_req_ready", prdy && (pr0 || pr1), 1);
                    chk("load_at_start", s_load, 1);
                end else chk("gnt_owner", gnt1, cur_id);
                chk("s_data_in", s_data_in, gnt1 ? din1 : din0);
                if (gcnt < 8) frame[4*gcnt +: 4] = gnt1 ? din1 : din0;
                gcnt++;
            end else if (gcnt != 0) begin
                chk("gnt_length", gcnt, 8);
                exp_q.push_back({cur_id, sort_desc(frame)});
                last_gnt_cyc = cyc - 1;
                gcnt = 0;
            end
            if (dout_valid) begin
                if (vcnt == 0) begin
                    chk("valid_latency", cyc - send_cyc, 2);
                    chk("result_expected", exp_q.size() > 0, 1);
                end
                if (exp_q.size() > 0 && vcnt < 8) begin
                    e = exp_q[0];
                    chk("dout", dout, e.d[4*vcnt +: 4]);
                    chk("dout_id", dout_id, e.id);
                end
                got.push_back(dout);
                vcnt++;
            end else if (vcnt != 0) begin
                chk("valid_burst", vcnt, 8);
                chk("done_latency", cyc - send_cyc, 10);
                chk("sort_once", n_sort, 1);
                chk("send_once", n_send, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    m_last = e.id;
                end
                vcnt = 0; n_sort = 0; n_send = 0;
                n_done++;
            end
            if (err) begin
                n_err++;
                err_cyc = cyc;
                chk("err_outside_burst", vcnt, 0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_sort = 0; n_send = 0;
            end
        end
        pr0 = req0; pr1 = req1; prdy = s_ready;
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int target);
        int i = 0;
        while (n_done < target && i < 1000) begin @(posedge clk); #1; i++; end
        chk("done_wait", n_done >= target, 1);
    endtask

    task automatic wait_gnt(input logic id);
        int i = 0;
        while (!(id ? gnt1 : gnt0) && i < 1000) begin @(posedge clk); #1; i++; end
        chk("gnt_wait", id ? gnt1 : gnt0, 1);
    endtask

    task automatic wait_served(input int n);
        int i = 0;
        while (served.size() < n && i < 3000) begin @(posedge clk); #1; i++; end
        chk("served_wait", served.size() >= n, 1);
    endtask

    logic [31:0] want;
    int d0, l0, e0;

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {gnt0, gnt1, dout, dout_valid, dout_id, done, err,
                                 s_load, s_sort, s_send, s_data_in}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_outputs", {gnt0, gnt1, dout, dout_valid, done, err,
                                s_load, s_sort, s_send, s_data_in}, 0);

        // Single frame: 3,1,4,1,5,9,2,6 -> 9,6,5,4,3,2,1,1
        f0 = 32'h6295_1413;
        got.delete(); served.delete(); d0 = n_done; l0 = n_loads;
        req0 = 1'b1;
        @(posedge clk); #1;
        chk("grant_latency", gnt0, 1);
        req0 = 1'b0;
        wait_done(d0 + 1);
        chk("t1_frames", n_done - d0, 1);
        chk("t1_loads", n_loads - l0, 1);
        chk("t1_count", got.size(), 8);
        chk("t1_owner", served.size() == 1 && served[0] == 1'b0, 1);
        want = 32'h1123_4569;
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_dout", got[i], want[4*i +: 4]);

        // Both requesting from reset: 0,1,0,1
        apply_reset();
        served.delete(); d0 = n_done;
        f0 = 32'h0123_4567; f1 = 32'hFEDC_BA98;
        req0 = 1'b1; req1 = 1'b1;
        wait_served(4);
        req0 = 1'b0; req1 = 1'b0;
        wait_done(d0 + 4);
        chk("t2_frames", served.size(), 4);
        for (int i = 0; i < 4 && i < served.size(); i++) chk("t2_order", served[i], i % 2);

        // req1 alone, repeatedly
        served.delete(); d0 = n_done;
        f1 = 32'h5A5A_0F0F;
        req1 = 1'b1;
        wait_served(3);
        req1 = 1'b0;
        wait_done(d0 + 3);
        chk("t3_frames", served.size(), 3);
        for (int i = 0; i < served.size(); i++) chk("t3_owner", served[i], 1);

        // Sorter never returns ready after load: timeout
        apply_reset();
        hang = 1'b1; e0 = n_err; d0 = n_done;
        f0 = 32'h8765_4321;
        req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        for (int i = 0; i < 600 && n_err == e0; i++) begin @(posedge clk); #1; end
        chk("t4_err", n_err - e0, 1);
        chk("t4_err_cycle", err_cyc - last_gnt_cyc, TIMEOUT + 1);
        repeat (10) @(posedge clk);
        #1 chk("t4_err_once", n_err - e0, 1);
        chk("t4_no_done", n_done - d0, 0);
        hang = 1'b0;
        repeat (4) @(posedge clk);
        #1 req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        wait_done(d0 + 1);
        chk("t4_recovered", n_done - d0, 1);

        // Reset in the 4th COLLECT cycle, then a clean frame
        f0 = 32'h1111_2222;
        req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        for (int i = 0; i < 600 && !s_send; i++) begin @(posedge clk); #1; end
        chk("t5_send_seen", s_send, 1);
        repeat (4) @(posedge clk);
        #1 chk("t5_in_collect", dout_valid, 1);
        #1 rst = 1'b1;
        #1 chk("t5_async_clear", {gnt0, gnt1, dout, dout_valid, dout_id, done, err,
                                  s_load, s_sort, s_send, s_data_in}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        got.delete(); served.delete(); d0 = n_done;
        f0 = 32'h7F00_0A03;
        req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        wait_done(d0 + 1);
        chk("t5_owner", served.size() == 1 && served[0] == 1'b0, 1);
        chk("t5_count", got.size(), 8);
        want = 32'h0000_37AF;
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t5_dout", got[i], want[4*i +: 4]);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sort_arbiter.md
# sort_arbiter

Shares the team's 8-entry, 4-bit sorter between two requesters. For one requester at a time, it loads an 8-element frame into the sorter, starts the sort, triggers unload, and returns the 8 result nibbles tagged with the requester id. It sits between the two frame sources and the sorter, and is the only driver of the sorter's Load, Sort, Send and Data_in inputs.

## Interface
- FRAME, 8, elements per frame; fixed to match the sorter.
- W, 4, element width.
- TIMEOUT, 255, maximum cycles spent in SETTLE or RUN before a fault.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset. The same net also drives the sorter.
- req0, req1  in  1  frame request. Hold high until the matching gnt is seen.
- din0, din1  in  W  element stream. Must be valid in every cycle the matching gnt is high.
- gnt0, gnt1  out  1  high for exactly FRAME consecutive cycles. Element k is sampled in the k-th gnt cycle.
- dout  out  W  result element (registered).
- dout_valid  out  1  qualifies dout.
- dout_id  out  1  requester that owns the current result frame.
- done  out  1  one-cycle pulse in the cycle after the last dout_valid.
- err  out  1  one-cycle pulse on a timeout.
- s_load, s_sort, s_send  out  1  sorter controls.
- s_data_in  out  W  sorter data input.
- s_ready, s_busy, s_waiting  in  1  sorter status.
- s_data_out  in  W  sorter result.

## Operation
- State machine: IDLE, LOAD, SETTLE, RUN, COLLECT, FIN.
- IDLE
  - If s_ready is high and req0 or req1 is high, choose a winner (rule below), latch it in `cur`, clear cnt, and go to LOAD.
  - Round-robin: if only one requester is asking, it wins. If both are asking, the requester not served last wins. After reset, req0 has priority.
- LOAD
  - gnt_cur = 1 and s_data_in = din_cur, both combinational.
  - s_load = 1 only when cnt == 0. The sorter takes the first element in the Load cycle and the next 7 in its internal load state.
  - cnt increments each cycle. After cnt == FRAME-1, go to SETTLE.
- SETTLE
  - Wait for s_ready (the sorter returns to idle through its init state).
  - In the cycle s_ready is high, s_sort = 1 (Mealy), then go to RUN.
- RUN
  - Wait for s_waiting.
  - In the cycle s_waiting is high, s_send = 1 (Mealy), clear cnt, then go to COLLECT.
- COLLECT
  - The sorter updates s_data_out in the cycle after each of its 8 send cycles.
  - Register dout <= s_data_out for FRAME consecutive cycles, starting the cycle after s_send. dout_valid is high one cycle later and dout_id = cur.
  - After FRAME captures, go to FIN.
- FIN
  - done = 1 for one cycle, last = cur, then go to IDLE.
- Timeout
  - A wait counter clears on entry to SETTLE and to RUN.
  - If it reaches TIMEOUT, pulse err, drop any active gnt, and go to IDLE. `last` is not updated.
- Width rules: cnt is 4 bits and the wait counter is 8 bits. Neither counter wraps; both saturate.
- Request dropped during LOAD: the frame still completes, and din is sampled as presented.
- A new request during SETTLE, RUN or COLLECT is held off until IDLE; there is no preemption.

## Timing
- Reset values: all outputs 0, state IDLE, last = 1 (so req0 wins first), cur = 0.
- Reset mid-frame clears immediately. No done or err is generated.
- Grant latency: req seen in IDLE with s_ready high at edge t, gnt high for cycles t+1 .. t+8.
- s_load is high only in cycle t+1. It must never be high for two cycles or while s_ready is low.
- s_sort and s_send are each exactly one cycle per frame.
- Results: if s_send is high in cycle u, dout_valid is high for cycles u+2 .. u+9 and done is high in u+10.
- Back-to-back: the next frame can start no earlier than the cycle after done, and only once s_ready is high again.

## Test plan
- Single frame, real sorter: req0 with din0 = 3,1,4,1,5,9,2,6.
  - gnt0 is high 8 cycles; s_load pulses once.
  - dout = 9,6,5,4,3,2,1,1 with dout_id = 0; done pulses once.
- Simultaneous req0 and req1 after reset:
  - req0 is served first, then req1.
  - With both held, service alternates 0,1,0,1 over 4 frames.
- req1 only, repeatedly: req1 is granted every frame, with no starvation or idle grants to req0.
- Sorter stub that holds s_ready low after load: err pulses TIMEOUT cycles after entering SETTLE, state returns to IDLE, and no done is generated.
- rst asserted in COLLECT cycle 4: all outputs drop to 0 asynchronously, and the next req0 runs a complete, correct frame.
- Protocol checks (assertions throughout): s_load, s_sort and s_send are each one cycle and mutually exclusive; gnt0 and gnt1 are never high together; dout_valid occurs in bursts of exactly 8.
